// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared word/line types and burst geometry
// Purpose: word and line types for the LC-3b memory path, plus burst constants.
// Ports: none (package).
package lc3b_types;

  localparam int WORD_W      = 16;
  localparam int LINE_W      = 128;
  localparam int BEATS       = LINE_W / WORD_W;
  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_W / 8);

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;

endpackage

// File: rtl/pmem_line_buffer.sv
// rtl/pmem_line_buffer.sv - 8x16 line staging register for the pmem burst
// Purpose: holds one cache line as BEATS words. The write path unpacks a latched line
//   and serves it one word per beat; the read path collects returned SRAM words and
//   presents them packed as a line.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   load_i        load all words from load_line_i
//   load_line_i   line to unpack (beat i = bits [16i+15:16i])
//   rd_idx_i      beat index for rd_word_o
//   rd_word_o     stored word at rd_idx_i
//   cap_en_i      capture cap_word_i into word cap_idx_i
//   cap_idx_i     capture slot
//   cap_word_i    word returned by the SRAM
//   line_o        packed line, including a capture happening this cycle
module pmem_line_buffer
  import lc3b_types::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  lc3b_line             load_line_i,
  input  logic [BEAT_BITS-1:0] rd_idx_i,
  output lc3b_word             rd_word_o,
  input  logic                 cap_en_i,
  input  logic [BEAT_BITS-1:0] cap_idx_i,
  input  lc3b_word             cap_word_i,
  output lc3b_line             line_o
);

  lc3b_word words_q [BEATS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BEATS; i++) words_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < BEATS; i++) words_q[i] <= load_line_i[i*WORD_W +: WORD_W];
    end else if (cap_en_i) begin
      words_q[cap_idx_i] <= cap_word_i;
    end
  end

  assign rd_word_o = words_q[rd_idx_i];

  // The word being captured is forwarded so the final beat can be registered into
  // pmem_rdata on the same edge that stores it here.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (cap_en_i && (cap_idx_i == BEAT_BITS'(i)))
        line_o[i*WORD_W +: WORD_W] = cap_word_i;
      else
        line_o[i*WORD_W +: WORD_W] = words_q[i];
    end
  end

endmodule

// File: rtl/pmem_line_server.sv
// rtl/pmem_line_server.sv - pmem responder serving 128-bit lines as 8x16 SRAM bursts
// Purpose: far end of the cache pmem_read/pmem_write/pmem_resp handshake. Each request is
//   latched, optionally delayed RESP_DELAY cycles, then moved as an 8-beat word burst to or
//   from a synchronous single-port SRAM, followed by a one-cycle pmem_resp.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   pmem_read, pmem_write   line requests, held until pmem_resp
//   pmem_address            byte address (line offset bits ignored)
//   pmem_wdata / pmem_rdata write line in / read line out (held until next read completes)
//   pmem_resp               one-cycle completion pulse
//   sram_addr/re/we/wdata   SRAM word port; sram_rdata returns one cycle after sram_re
//   busy                    high whenever not IDLE
//   proto_err               sticky: read and write requested together
module pmem_line_server
  import lc3b_types::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LINE_BITS  = 128,
  parameter int WORD_BITS  = 16,
  parameter int RESP_DELAY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_W-1:0]    pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic [ADDR_W-2:0]    sram_addr,
  output logic                 sram_re,
  output logic                 sram_we,
  output logic [WORD_BITS-1:0] sram_wdata,
  input  logic [WORD_BITS-1:0] sram_rdata,
  output logic                 busy,
  output logic                 proto_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_BURST, S_FLUSH, S_RESP, S_WAIT_DROP
  } pmem_state_t;

  localparam int LINE_ADDR_W = ADDR_W - OFFSET_BITS;
  localparam int DLY_W       = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
  localparam logic [DLY_W-1:0]     DLY_LAST  = DLY_W'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BEATS - 1);

  pmem_state_t              state_q, state_d;
  logic [BEAT_BITS-1:0]     beat_q, beat_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic [LINE_ADDR_W-1:0]   line_q, line_d;
  logic                     op_write_q, op_write_d;
  logic                     proto_err_q, proto_err_d;
  logic [LINE_BITS-1:0]     pmem_rdata_q, pmem_rdata_d;
  logic                     pmem_resp_q, pmem_resp_d;
  logic [ADDR_W-2:0]        sram_addr_q, sram_addr_d;
  logic                     sram_re_q, sram_re_d;
  logic                     sram_we_q, sram_we_d;
  logic [WORD_BITS-1:0]     sram_wdata_q, sram_wdata_d;
  logic                     busy_q, busy_d;

  logic                     req;
  logic                     buf_load;
  logic                     cap_en;
  logic [BEAT_BITS-1:0]     cap_idx;
  lc3b_word                 buf_rd_word;
  lc3b_line                 cap_line;
  logic                     unused_offset;

  assign req           = pmem_read | pmem_write;
  assign unused_offset = ^pmem_address[OFFSET_BITS-1:0];

  pmem_line_buffer u_line_buffer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (buf_load),
    .load_line_i (pmem_wdata),
    .rd_idx_i    (beat_d),
    .rd_word_o   (buf_rd_word),
    .cap_en_i    (cap_en),
    .cap_idx_i   (cap_idx),
    .cap_word_i  (sram_rdata),
    .line_o      (cap_line)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    dly_d       = dly_q;
    line_d      = line_q;
    op_write_d  = op_write_q;
    proto_err_d = proto_err_q;
    buf_load    = 1'b0;
    cap_en      = 1'b0;
    cap_idx     = beat_q - BEAT_BITS'(1);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          line_d     = pmem_address[ADDR_W-1:OFFSET_BITS];
          // A simultaneous read+write is flagged and served as a write.
          op_write_d = pmem_write;
          if (pmem_read && pmem_write) proto_err_d = 1'b1;
          buf_load   = 1'b1;
          dly_d      = '0;
          beat_d     = '0;
          state_d    = (RESP_DELAY == 0) ? S_BURST : S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_LAST) state_d = S_BURST;
        else                   dly_d   = dly_q + DLY_W'(1);
      end
      S_BURST: begin
        // Word requested at beat k-1 arrives during beat k.
        if (!op_write_q && (beat_q != '0)) cap_en = 1'b1;
        beat_d = beat_q + BEAT_BITS'(1);
        if (beat_q == BEAT_LAST) state_d = op_write_q ? S_RESP : S_FLUSH;
      end
      S_FLUSH: begin
        cap_en  = 1'b1;
        cap_idx = BEAT_LAST;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        // Holding off until the request drops keeps a held request from being re-served.
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    sram_re_d    = (state_d == S_BURST) && !op_write_d;
    sram_we_d    = (state_d == S_BURST) &&  op_write_d;
    sram_addr_d  = (state_d == S_BURST) ? {line_d, beat_d} : '0;
    sram_wdata_d = '0;
    if (sram_we_d)
      // With no delay the burst starts before the buffer has loaded, so take beat 0 directly.
      sram_wdata_d = buf_load ? pmem_wdata[WORD_BITS-1:0] : buf_rd_word;
    pmem_resp_d  = (state_d == S_RESP);
    pmem_rdata_d = (state_q == S_FLUSH) ? cap_line : pmem_rdata_q;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      dly_q        <= '0;
      line_q       <= '0;
      op_write_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      pmem_rdata_q <= '0;
      pmem_resp_q  <= 1'b0;
      sram_addr_q  <= '0;
      sram_re_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      dly_q        <= dly_d;
      line_q       <= line_d;
      op_write_q   <= op_write_d;
      proto_err_q  <= proto_err_d;
      pmem_rdata_q <= pmem_rdata_d;
      pmem_resp_q  <= pmem_resp_d;
      sram_addr_q  <= sram_addr_d;
      sram_re_q    <= sram_re_d;
      sram_we_q    <= sram_we_d;
      sram_wdata_q <= sram_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign pmem_rdata = pmem_rdata_q;
  assign pmem_resp  = pmem_resp_q;
  assign sram_addr  = sram_addr_q;
  assign sram_re    = sram_re_q;
  assign sram_we    = sram_we_q;
  assign sram_wdata = sram_wdata_q;
  assign busy       = busy_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_pmem_line_server.sv
// tb/tb_pmem_line_server.sv - directed self-checking bench for pmem_line_server
module tb_pmem_line_server;

  localparam int ADDR_W     = 16;
  localparam int LINE_BITS  = 128;
  localparam int WORD_BITS  = 16;
  localparam int RESP_DELAY = 4;

  logic                 clk;
  logic                 reset;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [ADDR_W-1:0]    pmem_address;
  logic [LINE_BITS-1:0] pmem_wdata;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;
  logic [ADDR_W-2:0]    sram_addr;
  logic                 sram_re;
  logic                 sram_we;
  logic [WORD_BITS-1:0] sram_wdata;
  logic [WORD_BITS-1:0] sram_rdata;
  logic                 busy;
  logic                 proto_err;

  pmem_line_server #(
    .ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS), .RESP_DELAY(RESP_DELAY)
  ) dut (
    .clk(clk), .reset(reset),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:32767];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          n_re, n_we, n_resp, resp_cyc, re_first;
  logic [14:0] re_addr [8];
  logic [14:0] we_addr [8];
  logic [15:0] we_data [8];
  logic [127:0] resp_data;

  task automatic clear_log();
    n_re = 0; n_we = 0; n_resp = 0; resp_cyc = -1; re_first = -1;
  endtask

  task automatic step();
    @(negedge clk);
    if (sram_re) begin
      if (n_re == 0) re_first = cyc;
      if (n_re < 8) re_addr[n_re] = sram_addr;
      n_re++;
    end
    if (sram_we) begin
      if (n_we < 8) begin we_addr[n_we] = sram_addr; we_data[n_we] = sram_wdata; end
      n_we++;
    end
    if (pmem_resp) begin
      n_resp++;
      resp_cyc  = cyc;
      resp_data = pmem_rdata;
    end
  endtask

  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [127:0] wd,
                         input int hold, input int idle, output int t0);
    clear_log();
    t0 = cyc;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    for (int i = 0; i < 60 && n_resp == 0; i++) step();
    chk({tag, "_resp_seen"}, n_resp, 1);
    for (int i = 0; i < hold; i++) step();
    pmem_read = 1'b0; pmem_write = 1'b0;
    for (int i = 0; i < idle; i++) step();
  endtask

  localparam logic [127:0] LINE_A = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [127:0] LINE_5 = 128'h5507_5506_5505_5504_5503_5502_5501_5500;
  localparam logic [127:0] LINE_1 = 128'h1117_1116_1115_1114_1113_1112_1111_1110;
  localparam logic [127:0] LINE_C = 128'hC007_C006_C005_C004_C003_C002_C001_C000;
  localparam logic [127:0] LINE_E = 128'hE007_E006_E005_E004_E003_E002_E001_E000;

  int t0, t_prev, r_prev;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[15'h0918 + i] = 16'hA000 + 16'(i);
    sram_rdata = '0;
    reset = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0;
    clear_log();

    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_resp", pmem_resp, 0);
    chk("rst_rdata", pmem_rdata, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_sram_strobes", {sram_re, sram_we}, 0);
    reset = 1'b0;
    step();

    // 1: read 0x1234
    run_txn("t1", 1'b1, 1'b0, 16'h1234, '0, 0, 3, t0);
    chk("t1_latency", resp_cyc - t0, 14);
    chk("t1_first_re", re_first - t0, RESP_DELAY + 1);
    chk("t1_n_re", n_re, 8);
    chk("t1_n_we", n_we, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_addr%0d", i), re_addr[i], 15'h0918 + 15'(i));
    chk("t1_rdata", resp_data, LINE_A);

    // 2: write 0x1230, then read it back
    run_txn("t2w", 1'b0, 1'b1, 16'h1230, LINE_5, 0, 3, t0);
    chk("t2_latency", resp_cyc - t0, 13);
    chk("t2_n_we", n_we, 8);
    chk("t2_n_re", n_re, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_waddr%0d", i), we_addr[i], 15'h0918 + 15'(i));
      chk($sformatf("t2_wdata%0d", i), we_data[i], 16'h5500 + 16'(i));
    end
    chk("t2_rdata_held", pmem_rdata, LINE_A);
    run_txn("t2r", 1'b1, 1'b0, 16'h1230, '0, 0, 3, t0);
    chk("t2_readback", resp_data, LINE_5);

    // 3: request held 5 cycles past resp
    run_txn("t3", 1'b1, 1'b0, 16'h1234, '0, 5, 0, t0);
    chk("t3_busy_held", busy, 1);
    for (int i = 0; i < 3; i++) step();
    chk("t3_n_resp", n_resp, 1);
    chk("t3_n_re", n_re, 8);
    chk("t3_rdata", resp_data, LINE_5);
    chk("t3_idle", busy, 0);

    // 4: write-back then immediate load; request low for one WAIT_DROP cycle
    run_txn("t4w", 1'b0, 1'b1, 16'h2000, LINE_1, 0, 1, t0);
    r_prev = resp_cyc;
    t_prev = cyc;
    chk("t4_gap", t_prev - r_prev, 1);
    step();
    run_txn("t4r", 1'b1, 1'b0, 16'h2000, '0, 0, 3, t0);
    chk("t4_accept", t0 - r_prev, 2);
    chk("t4_first_re", re_first - t0, RESP_DELAY + 1);
    chk("t4_latency", resp_cyc - t0, 14);
    chk("t4_readback", resp_data, LINE_1);

    // 5: reset at beat 3 of a write
    clear_log();
    pmem_write = 1'b1; pmem_address = 16'h3000; pmem_wdata = LINE_C;
    for (int i = 0; i < 40 && n_we < 4; i++) step();
    chk("t5_reached_beat3", n_we, 4);
    reset = 1'b1; pmem_write = 1'b0;
    #1;
    chk("t5_rst_we", sram_we, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", sram_addr, 0);
    chk("t5_rst_wdata", sram_wdata, 0);
    chk("t5_rst_rdata", pmem_rdata, 0);
    step(); step();
    reset = 1'b0;
    clear_log();
    for (int i = 0; i < 20; i++) step();
    chk("t5_no_resp", n_resp, 0);
    chk("t5_mem_beat2", mem[15'h1802], 16'hC002);
    chk("t5_mem_beat3", mem[15'h1803], 16'h0000);
    run_txn("t5r", 1'b1, 1'b0, 16'h1230, '0, 0, 3, t0);
    chk("t5_latency", resp_cyc - t0, 14);
    chk("t5_rdata", resp_data, LINE_5);

    // 6: read and write together
    run_txn("t6", 1'b1, 1'b1, 16'h4000, LINE_E, 0, 3, t0);
    chk("t6_proto_err", proto_err, 1);
    chk("t6_n_we", n_we, 8);
    chk("t6_n_re", n_re, 0);
    chk("t6_latency", resp_cyc - t0, 13);
    chk("t6_mem", mem[15'h2005], 16'hE005);
    run_txn("t6r", 1'b1, 1'b0, 16'h1230, '0, 0, 3, t0);
    chk("t6_sticky", proto_err, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_clear", proto_err, 0);
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
